maxpool2x2_stream: RTL and testbench
====================================

Name: maxpool2x2_stream

Overview:
Streaming 2x2/stride-2 max-pooling stage with optional ReLU, placed directly downstream of convolutional_layer.
- Consumes one feature-map channel as raster-ordered 16-bit signed pixels over a valid/ready handshake.
- Emits the pooled map (W/2 x H/2) in raster order.
- Uses a half-width line buffer, so no full-frame storage is needed.

Parameters:
- W, 256: input frame width in pixels; must be even (elaboration error otherwise).
- H, 256: input frame height in pixels; must be even (elaboration error otherwise).
- DATA_W, 16: pixel width, two's-complement signed.
- RELU, 1: 1 = clamp negative pooled results to 0; 0 = pass them through unchanged.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid pixel.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  DATA_W  input pixel, signed, raster order (row-major, col 0 first).
- out_valid  output  1  out_data holds a pooled pixel.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  DATA_W  pooled pixel, signed.
- out_last  output  1  qualifies the final pooled pixel of a frame; valid only with out_valid.
- frame_done  output  1  one-cycle pulse after the last input pixel of a frame is accepted.

Behaviour:
- Interface: one clock `clk`; asynchronous active-low reset `rst_n`.
- Accept: a pixel is accepted on a rising edge with in_valid && in_ready.
- Backpressure: in_ready = !(out_valid && !out_ready). Input is blocked only while a pooled result is stalled, which is conservative.
- Counters: col 0..W-1 and row 0..H-1 advance per accepted pixel. When col = W-1, col -> 0 and row++. When row = H-1 and col = W-1, both wrap to 0 for the next frame.
- Even col: pair_reg <= in_data.
- Odd col: pair_max = signed max(pair_reg, in_data).
- Even row, odd col: linebuf[col>>1] <= pair_max.
- Odd row, odd col: res = signed max(linebuf[col>>1], pair_max).
  - If RELU=1 and res < 0, res = 0.
  - out_data <= res, out_valid <= 1.
  - out_last <= (row = H-1 && col = W-1).
- Latency: out_valid rises on the clock edge that accepts the 4th pixel of a 2x2 window; result is visible the following cycle.
- Throughput: 1 input pixel/cycle when unstalled.
- Output register: out_valid clears on out_valid && out_ready unless a new result loads in the same cycle. Simultaneous handshake plus new load: the new value replaces the old one; nothing is dropped.
- Stall: while stalled, out_data, out_valid and out_last hold stable.
- Comparisons: all compares are signed over the full DATA_W; no width growth; the output is exactly an input value or 0.
- frame_done: asserted for exactly one cycle, the cycle after the pixel at (H-1, W-1) is accepted.
- Reset values: out_valid=0, out_data=0, out_last=0, frame_done=0, in_ready=1, col=0, row=0, pair_reg=0.
- linebuf is not reset; it is always written before it is read within a frame.
- Reset mid-frame: the partial frame is discarded and any pending output is dropped. The next accepted pixel is treated as (0,0).
- in_valid low with counters mid-window: state holds indefinitely; no timeout.

Test Plan:
1. W=4, H=4, RELU=1, out_ready=1; feed pixels 0..15 back-to-back -> outputs 5, 7, 13, 15 in order; out_last only with 15; frame_done pulses once, one cycle after pixel 15 is accepted.
2. W=4, H=4, all pixels 0xFFFD (-3) -> RELU=1 gives four outputs of 0x0000; RELU=0 gives four outputs of 0xFFFD.
3. Signed compare: one window {0x8000, 0x7FFF, 0xFFFF, 0x0001}, others 0 -> that window outputs 0x7FFF, not 0x8000.
4. Scenario 1 with out_ready low for 5 cycles once the first result is valid:
   - During the stall: out_data holds 5, in_ready=0, no input lost.
   - After release: output sequence is identical to scenario 1.
5. Assert rst_n low after 6 accepted pixels, release, then feed the full frame from scenario 1 -> exactly 5, 7, 13, 15 with no stale output.
6. Two consecutive 4x4 frames with no gap (second frame = 16..31) -> outputs 5, 7, 13, 15, 21, 23, 29, 31; out_last on 15 and 31; two frame_done pulses.

Source files
------------

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over one raster-ordered signed feature-map channel,
// with optional ReLU on the pooled result and a half-width line buffer for row pairing.
module maxpool2x2_stream #(
    parameter int W      = 256,
    parameter int H      = 256,
    parameter int DATA_W = 16,
    parameter int RELU   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done
);

    localparam int HALF_W = W / 2;
    localparam int LBW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int CW     = LBW + 1;
    localparam int RW     = (H > 2) ? $clog2(H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    if ((W % 2) != 0) begin : g_bad_w
        $error("maxpool2x2_stream: W must be even");
    end
    if ((H % 2) != 0) begin : g_bad_h
        $error("maxpool2x2_stream: H must be even");
    end

    function automatic logic [DATA_W-1:0] signed_max(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [DATA_W-1:0] pair_r;
    logic [DATA_W-1:0] linebuf_r [0:HALF_W-1];
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              frame_done_r;

    logic              accept_s;
    logic              col_last_s;
    logic              row_last_s;
    logic [LBW-1:0]    lb_idx_s;
    logic [DATA_W-1:0] pair_max_s;
    logic [DATA_W-1:0] win_max_s;
    logic [DATA_W-1:0] res_s;
    logic              load_s;

    // Input stalls only while a finished result is waiting on the consumer.
    assign in_ready   = !(out_valid_r && !out_ready);
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign frame_done = frame_done_r;

    // Window datapath: horizontal pair max, then vertical max against the buffered row.
    always_comb begin
        accept_s   = in_valid && in_ready;
        col_last_s = (col_r == COL_LAST);
        row_last_s = (row_r == ROW_LAST);
        lb_idx_s   = col_r[CW-1:1];
        pair_max_s = signed_max(pair_r, in_data);
        win_max_s  = signed_max(linebuf_r[lb_idx_s], pair_max_s);
        if ((RELU != 0) && win_max_s[DATA_W-1]) begin
            res_s = {DATA_W{1'b0}};
        end else begin
            res_s = win_max_s;
        end
        load_s = accept_s && col_r[0] && row_r[0];
    end

    // Raster position counters and the even-column pixel holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r  <= {CW{1'b0}};
            row_r  <= {RW{1'b0}};
            pair_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            if (!col_r[0]) begin
                pair_r <= in_data;
            end
            if (col_last_s) begin
                col_r <= {CW{1'b0}};
                row_r <= row_last_s ? {RW{1'b0}} : row_r + RW'(1'b1);
            end else begin
                col_r <= col_r + CW'(1'b1);
            end
        end
    end

    // Even rows park their pair maxima here; every slot is written before the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept_s && col_r[0] && !row_r[0]) begin
            linebuf_r[lb_idx_s] <= pair_max_s;
        end
    end

    // Output register: a new load overrides a simultaneous drain, otherwise hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_data_r  <= res_s;
            out_valid_r <= 1'b1;
            out_last_r  <= col_last_s && row_last_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    // One-cycle pulse following acceptance of the frame's final pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= accept_s && col_last_s && row_last_s;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream on a 4x4 frame; a RELU=1 and a RELU=0 instance
// share the same stimulus so both clamp modes are checked side by side.
module tb_maxpool2x2_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready, out_valid, out_last, frame_done;
    logic [15:0] out_data;
    logic        in_ready0, out_valid0, out_last0, frame_done0;
    logic [15:0] out_data0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int last_acc = 0;
    logic [16:0] q1[$];
    logic [16:0] q0[$];

    maxpool2x2_stream #(.W(4), .H(4), .DATA_W(16), .RELU(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .frame_done(frame_done)
    );

    maxpool2x2_stream #(.W(4), .H(4), .DATA_W(16), .RELU(0)) dut_norelu (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_last(out_last0), .frame_done(frame_done0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: log every completed handshake and frame_done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) q1.push_back({out_last, out_data});
            if (out_valid0 && out_ready) q0.push_back({out_last0, out_data0});
            if (frame_done) begin
                fd_cnt = fd_cnt + 1;
                fd_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [15:0] v);
        int n;
        n = 0;
        in_data = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: pixel %h not accepted within 50 cycles", v);
        end
        @(posedge clk); #1;
        last_acc = cyc;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, frame_done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl: got v/l/fd/rdy=%b expected 0001", {out_valid, out_last, frame_done, in_ready});
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0000", out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] exp [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
        int b, f;
        b = q1.size(); f = fd_cnt;
        for (int i = 0; i < 16; i++) send(16'(i));
        drain();
        checks++;
        if (q1.size() - b !== 4) begin
            errors++;
            $display("FAIL basic_count: got %0d outputs expected 4", q1.size() - b);
        end
        for (int k = 0; k < 4; k++) begin
            if (b + k < q1.size()) begin
                checks++;
                if (q1[b + k] !== {(k == 3), exp[k]}) begin
                    errors++;
                    $display("FAIL basic_out%0d: got last/data=%h expected %h", k, q1[b + k], {(k == 3), exp[k]});
                end
            end
        end
        checks++;
        if (fd_cnt - f !== 1) begin
            errors++;
            $display("FAIL basic_fd_count: got %0d pulses expected 1", fd_cnt - f);
        end
        checks++;
        if (fd_cyc !== last_acc) begin
            errors++;
            $display("FAIL basic_fd_timing: pulse in cycle %0d expected %0d", fd_cyc, last_acc);
        end
    endtask

    task automatic test_relu();
        int b1, b0;
        b1 = q1.size(); b0 = q0.size();
        for (int i = 0; i < 16; i++) send(16'hFFFD);
        drain();
        checks += 2;
        if (q1.size() - b1 !== 4) begin
            errors++;
            $display("FAIL relu1_count: got %0d expected 4", q1.size() - b1);
        end
        if (q0.size() - b0 !== 4) begin
            errors++;
            $display("FAIL relu0_count: got %0d expected 4", q0.size() - b0);
        end
        for (int k = 0; k < 4; k++) begin
            if (b1 + k < q1.size() && b0 + k < q0.size()) begin
                checks += 2;
                if (q1[b1 + k] !== {(k == 3), 16'h0000}) begin
                    errors++;
                    $display("FAIL relu1_out%0d: got %h expected %h", k, q1[b1 + k], {(k == 3), 16'h0000});
                end
                if (q0[b0 + k] !== {(k == 3), 16'hFFFD}) begin
                    errors++;
                    $display("FAIL relu0_out%0d: got %h expected %h", k, q0[b0 + k], {(k == 3), 16'hFFFD});
                end
            end
        end
    endtask

    task automatic test_signed();
        logic [15:0] v;
        int b1, b0;
        b1 = q1.size(); b0 = q0.size();
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       v = 16'h8000;
                1:       v = 16'h7FFF;
                4:       v = 16'hFFFF;
                5:       v = 16'h0001;
                default: v = 16'h0000;
            endcase
            send(v);
        end
        drain();
        checks += 2;
        if (q1.size() - b1 !== 4) begin
            errors++;
            $display("FAIL signed_count: got %0d expected 4", q1.size() - b1);
        end else if (q1[b1] !== {1'b0, 16'h7FFF}) begin
            errors++;
            $display("FAIL signed_relu1: got %h expected 07fff", q1[b1]);
        end
        if (q0.size() - b0 !== 4) begin
            errors++;
            $display("FAIL signed_count0: got %0d expected 4", q0.size() - b0);
        end else if (q0[b0 + 1] !== 17'h00000 || q0[b0] !== {1'b0, 16'h7FFF}) begin
            errors++;
            $display("FAIL signed_relu0: got %h,%h expected 07fff,00000", q0[b0], q0[b0 + 1]);
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
        int b;
        b = q1.size();
        fork
            begin
                for (int i = 0; i < 16; i++) send(16'(i));
            end
            begin
                int n;
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!out_valid && n < 100);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 16'd5}) begin
                        errors++;
                        $display("FAIL stall_hold: got v/rdy/data=%b/%b/%h expected 1/0/0005", out_valid, in_ready, out_data);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (q1.size() - b !== 4) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 4", q1.size() - b);
        end
        for (int k = 0; k < 4; k++) begin
            if (b + k < q1.size()) begin
                checks++;
                if (q1[b + k] !== {(k == 3), exp[k]}) begin
                    errors++;
                    $display("FAIL stall_out%0d: got %h expected %h", k, q1[b + k], {(k == 3), exp[k]});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
        int b;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(16'(i + 100));
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop: got out_valid=%b expected 0", out_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        b = q1.size();
        for (int i = 0; i < 16; i++) send(16'(i));
        drain();
        checks++;
        if (q1.size() - b !== 4) begin
            errors++;
            $display("FAIL midreset_count: got %0d expected 4", q1.size() - b);
        end
        for (int k = 0; k < 4; k++) begin
            if (b + k < q1.size()) begin
                checks++;
                if (q1[b + k] !== {(k == 3), exp[k]}) begin
                    errors++;
                    $display("FAIL midreset_out%0d: got %h expected %h", k, q1[b + k], {(k == 3), exp[k]});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [8] = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd21, 16'd23, 16'd29, 16'd31};
        int b, f;
        b = q1.size(); f = fd_cnt;
        for (int i = 0; i < 32; i++) send(16'(i + 0));
        drain();
        checks++;
        if (q1.size() - b !== 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 8", q1.size() - b);
        end
        for (int k = 0; k < 8; k++) begin
            if (b + k < q1.size()) begin
                checks++;
                if (q1[b + k] !== {(k == 3 || k == 7), exp[k]}) begin
                    errors++;
                    $display("FAIL b2b_out%0d: got %h expected %h", k, q1[b + k], {(k == 3 || k == 7), exp[k]});
                end
            end
        end
        checks++;
        if (fd_cnt - f !== 2) begin
            errors++;
            $display("FAIL b2b_fd_count: got %0d pulses expected 2", fd_cnt - f);
        end
        checks++;
        if (fd_cyc !== last_acc) begin
            errors++;
            $display("FAIL b2b_fd_timing: pulse in cycle %0d expected %0d", fd_cyc, last_acc);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_relu();
        test_signed();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
